// File: rtl/exception_controller.sv
// Exception sequencer for the single-cycle MIPS core: latches three edge-triggered
// sources, takes them by fixed priority, saves/restores the PC and guards handlers with a watchdog.
module exception_controller #(
   parameter logic [31:0] HANDLER_BASE = 32'h0000_0800,
   parameter int          VEC_SHIFT    = 7,
   parameter int          TIMEOUT      = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        expsrc0,
   input  logic        expsrc1,
   input  logic        expsrc2,
   input  logic [31:0] pc_next,
   input  logic        eret,
   input  logic        mask_we,
   input  logic [2:0]  mask_wdata,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        in_service,
   output logic [2:0]  pending,
   output logic [2:0]  mask,
   output logic [10:0] cnt_exc,
   output logic        spurious_eret,
   output logic        wdog_fire
);

   localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic {RUN, SERVICE} state_t;

   state_t          state;
   logic [2:0]      prev;
   logic [WD_W-1:0] wdog_cnt;

   logic [2:0]  src;
   logic [2:0]  rise;
   logic [2:0]  eligible;
   logic [1:0]  winner;
   logic [2:0]  winner_onehot;
   logic        take;
   logic        timeout;
   logic        ret;

   assign src      = {expsrc2, expsrc1, expsrc0};
   assign rise     = src & ~prev;
   assign eligible = pending & ~mask;

   always_comb begin
      winner        = 2'd0;
      winner_onehot = 3'b000;
      if (eligible[0]) begin
         winner        = 2'd0;
         winner_onehot = 3'b001;
      end else if (eligible[1]) begin
         winner        = 2'd1;
         winner_onehot = 3'b010;
      end else if (eligible[2]) begin
         winner        = 2'd2;
         winner_onehot = 3'b100;
      end
   end

   // Redirect decisions use only registered state and eret, never pc_next.
   assign take    = (state == RUN) && (eligible != 3'b000);
   assign timeout = (state == SERVICE) && (wdog_cnt == WD_LAST);
   assign ret     = (state == SERVICE) && (eret || timeout);

   assign pc_redirect = take || ret;
   assign redirect_pc = ret ? epc : HANDLER_BASE + (32'(winner) << VEC_SHIFT);
   assign in_service  = (state == SERVICE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= RUN;
         prev          <= 3'b000;
         pending       <= 3'b000;
         mask          <= 3'b000;
         epc           <= 32'h0;
         cause         <= 2'd0;
         cnt_exc       <= 11'd0;
         wdog_cnt      <= '0;
         spurious_eret <= 1'b0;
         wdog_fire     <= 1'b0;
      end else begin
         prev <= src;
         if (mask_we)
            mask <= mask_wdata;

         // A new edge on the source being taken wins over its clear.
         if (take)
            pending <= (pending & ~winner_onehot) | rise;
         else
            pending <= pending | rise;

         case (state)
            RUN: begin
               if (eret)
                  spurious_eret <= 1'b1;
               if (take) begin
                  epc      <= pc_next;
                  cause    <= winner;
                  cnt_exc  <= cnt_exc + 11'd1;
                  wdog_cnt <= '0;
                  state    <= SERVICE;
               end
            end
            SERVICE: begin
               if (ret) begin
                  state <= RUN;
                  if (!eret)
                     wdog_fire <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + WD_W'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_exception_controller.sv
// Directed bench for exception_controller: a per-cycle vector table plus hand-written
// sequences for reset, watchdog, back-to-back and counter-wrap behaviour.
module tb_exception_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        expsrc0 = 1'b0, expsrc1 = 1'b0, expsrc2 = 1'b0;
   logic [31:0] pc_next = 32'h0;
   logic        eret = 1'b0;
   logic        mask_we = 1'b0;
   logic [2:0]  mask_wdata = 3'b000;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic        in_service;
   logic [2:0]  pending;
   logic [2:0]  mask;
   logic [10:0] cnt_exc;
   logic        spurious_eret;
   logic        wdog_fire;

   exception_controller dut (
      .clk(clk), .reset(reset),
      .expsrc0(expsrc0), .expsrc1(expsrc1), .expsrc2(expsrc2),
      .pc_next(pc_next), .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
      .in_service(in_service), .pending(pending), .mask(mask), .cnt_exc(cnt_exc),
      .spurious_eret(spurious_eret), .wdog_fire(wdog_fire)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  src;
      logic        er;
      logic        mwe;
      logic [2:0]  mwd;
      logic [31:0] pc;
      logic        e_redir;
      logic [31:0] e_rpc;
      logic        e_svc;
      logic [2:0]  e_pend;
      logic [2:0]  e_mask;
      logic [1:0]  e_cause;
      logic [10:0] e_cnt;
      logic [31:0] e_epc;
   } vec_t;

   vec_t tbl[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, req);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      {expsrc2, expsrc1, expsrc0} = 3'b000;
      eret = 1'b0; mask_we = 1'b0; mask_wdata = 3'b000; pc_next = 32'h0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [127:0] reset_image();
      return {pc_redirect, redirect_pc, epc, cause, in_service, pending, mask, cnt_exc,
              spurious_eret, wdog_fire};
   endfunction

   localparam logic [127:0] RESET_EXP =
      {1'b0, 32'h800, 32'h0, 2'd0, 1'b0, 3'b000, 3'b000, 11'd0, 1'b0, 1'b0};

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int          got;
      int          misses;
      logic [127:0] act, req;

      // src, eret, mwe, mwd, pc | redir, rpc, svc, pend, mask, cause, cnt, epc
      tbl.push_back('{3'b000,0,0,3'b000,32'h040, 0,32'h000,0,3'b000,3'b000,2'd0,11'd0,32'h000});
      tbl.push_back('{3'b010,0,0,3'b000,32'h040, 0,32'h000,0,3'b000,3'b000,2'd0,11'd0,32'h000});
      tbl.push_back('{3'b000,0,0,3'b000,32'h040, 1,32'h880,0,3'b010,3'b000,2'd0,11'd0,32'h000});
      tbl.push_back('{3'b000,0,0,3'b000,32'h880, 0,32'h000,1,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,0,0,3'b000,32'h884, 0,32'h000,1,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,0,0,3'b000,32'h888, 0,32'h000,1,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,0,0,3'b000,32'h88c, 0,32'h000,1,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,1,0,3'b000,32'h890, 1,32'h040,1,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,0,0,3'b000,32'h040, 0,32'h000,0,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b101,0,0,3'b000,32'h100, 0,32'h000,0,3'b000,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,0,0,3'b000,32'h100, 1,32'h800,0,3'b101,3'b000,2'd1,11'd1,32'h040});
      tbl.push_back('{3'b000,0,0,3'b000,32'h800, 0,32'h000,1,3'b100,3'b000,2'd0,11'd2,32'h100});
      tbl.push_back('{3'b000,1,0,3'b000,32'h804, 1,32'h100,1,3'b100,3'b000,2'd0,11'd2,32'h100});
      tbl.push_back('{3'b000,0,0,3'b000,32'h100, 1,32'h900,0,3'b100,3'b000,2'd0,11'd2,32'h100});
      tbl.push_back('{3'b000,0,0,3'b000,32'h900, 0,32'h000,1,3'b000,3'b000,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,1,0,3'b000,32'h904, 1,32'h100,1,3'b000,3'b000,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,0,0,3'b000,32'h100, 0,32'h000,0,3'b000,3'b000,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,0,1,3'b001,32'h200, 0,32'h000,0,3'b000,3'b000,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b001,0,0,3'b000,32'h200, 0,32'h000,0,3'b000,3'b001,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,0,0,3'b000,32'h200, 0,32'h000,0,3'b001,3'b001,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,0,1,3'b000,32'h300, 0,32'h000,0,3'b001,3'b001,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,0,0,3'b000,32'h300, 1,32'h800,0,3'b001,3'b000,2'd2,11'd3,32'h100});
      tbl.push_back('{3'b000,0,0,3'b000,32'h800, 0,32'h000,1,3'b000,3'b000,2'd0,11'd4,32'h300});
      tbl.push_back('{3'b000,1,0,3'b000,32'h804, 1,32'h300,1,3'b000,3'b000,2'd0,11'd4,32'h300});
      tbl.push_back('{3'b000,0,0,3'b000,32'h300, 0,32'h000,0,3'b000,3'b000,2'd0,11'd4,32'h300});
      tbl.push_back('{3'b100,0,0,3'b000,32'h300, 0,32'h000,0,3'b000,3'b000,2'd0,11'd4,32'h300});
      tbl.push_back('{3'b000,0,0,3'b000,32'h500, 1,32'h900,0,3'b100,3'b000,2'd0,11'd4,32'h300});
      tbl.push_back('{3'b010,0,1,3'b100,32'h900, 0,32'h000,1,3'b000,3'b000,2'd2,11'd5,32'h500});
      tbl.push_back('{3'b000,1,0,3'b000,32'h904, 1,32'h500,1,3'b010,3'b100,2'd2,11'd5,32'h500});
      tbl.push_back('{3'b010,0,0,3'b000,32'h600, 1,32'h880,0,3'b010,3'b100,2'd2,11'd5,32'h500});
      tbl.push_back('{3'b000,0,0,3'b000,32'h880, 0,32'h000,1,3'b010,3'b100,2'd1,11'd6,32'h600});
      tbl.push_back('{3'b000,1,0,3'b000,32'h884, 1,32'h600,1,3'b010,3'b100,2'd1,11'd6,32'h600});
      tbl.push_back('{3'b000,0,0,3'b000,32'h700, 1,32'h880,0,3'b010,3'b100,2'd1,11'd6,32'h600});
      tbl.push_back('{3'b100,1,0,3'b000,32'h880, 1,32'h700,1,3'b000,3'b100,2'd1,11'd7,32'h700});
      tbl.push_back('{3'b000,0,0,3'b000,32'h700, 0,32'h000,0,3'b100,3'b100,2'd1,11'd7,32'h700});
      tbl.push_back('{3'b000,0,1,3'b000,32'h700, 0,32'h000,0,3'b100,3'b100,2'd1,11'd7,32'h700});

      // Reset values, checked before any clock edge leaves reset.
      do_reset();
      #1 chk("reset_values", reset_image(), RESET_EXP);

      // Vector table: drive after the falling edge, sample 1 time unit later.
      @(negedge clk);
      foreach (tbl[i]) begin
         {expsrc2, expsrc1, expsrc0} = tbl[i].src;
         eret = tbl[i].er; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd; pc_next = tbl[i].pc;
         #1;
         act = {pc_redirect, (pc_redirect ? redirect_pc : 32'h0), in_service, pending, mask,
                cause, cnt_exc, epc};
         req = {tbl[i].e_redir, tbl[i].e_rpc, tbl[i].e_svc, tbl[i].e_pend, tbl[i].e_mask,
                tbl[i].e_cause, tbl[i].e_cnt, tbl[i].e_epc};
         chk($sformatf("vec%0d", i), act, req);
         @(negedge clk);
      end
      mask_we = 1'b0; eret = 1'b0;
      #1 chk("flags_quiet_after_table", {spurious_eret, wdog_fire}, 2'b00);

      // ERET outside SERVICE: no redirect, sticky spurious flag.
      do_reset();
      eret = 1'b1;
      #1 chk("spurious_no_redirect", pc_redirect, 1'b0);
      @(negedge clk);
      eret = 1'b0;
      #1 chk("spurious_flag", {spurious_eret, in_service}, 2'b10);

      // Asynchronous reset in the middle of a handler.
      expsrc0 = 1'b1;
      @(negedge clk);
      expsrc0 = 1'b0; pc_next = 32'h1000;
      #1 chk("take_before_async_reset", {pc_redirect, redirect_pc}, {1'b1, 32'h800});
      @(negedge clk);
      #1 chk("service_before_async_reset", {in_service, epc, cnt_exc}, {1'b1, 32'h1000, 11'd1});
      #1 reset = 1'b1;
      #1 chk("async_reset_values", reset_image(), RESET_EXP);

      // Source held high across reset release registers one edge on the first clock.
      expsrc1 = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1 chk("held_src_not_yet", pending, 3'b000);
      @(negedge clk);
      #1 chk("held_src_edge", {pending, pc_redirect, redirect_pc}, {3'b010, 1'b1, 32'h880});
      expsrc1 = 1'b0;

      // Watchdog return without ERET.
      do_reset();
      expsrc0 = 1'b1;
      @(negedge clk);
      expsrc0 = 1'b0; pc_next = 32'h1234;
      @(negedge clk);
      pc_next = 32'h800;
      got = 0;
      for (int k = 1; k <= 1100; k++) begin
         #1;
         if (pc_redirect) begin
            got = k;
            break;
         end
         @(negedge clk);
      end
      chk("wdog_cycle", 32'(got), 32'd1024);
      chk("wdog_target", redirect_pc, 32'h1234);
      @(negedge clk);
      #1 chk("wdog_after", {wdog_fire, in_service, pc_redirect}, 3'b100);

      // ERET in the same cycle as the timeout counts as an ERET return.
      do_reset();
      expsrc0 = 1'b1;
      @(negedge clk);
      expsrc0 = 1'b0; pc_next = 32'h2468;
      @(negedge clk);
      repeat (1023) @(negedge clk);
      eret = 1'b1;
      #1 chk("eret_at_timeout_redirect", {pc_redirect, redirect_pc}, {1'b1, 32'h2468});
      @(negedge clk);
      eret = 1'b0;
      #1 chk("eret_at_timeout_flags", {wdog_fire, in_service}, 2'b00);

      // 2048 take/ERET pairs wrap the exception counter.
      do_reset();
      misses = 0;
      for (int i = 0; i < 2048; i++) begin
         if (i == 2047) #1 chk("cnt_before_wrap", cnt_exc, 11'd2047);
         expsrc0 = 1'b1;
         @(negedge clk);
         expsrc0 = 1'b0;
         #1 if (!pc_redirect) misses++;
         @(negedge clk);
         eret = 1'b1;
         @(negedge clk);
         eret = 1'b0;
      end
      chk("wrap_takes_redirected", 32'(misses), 32'd0);
      #1 chk("cnt_wrapped", {cnt_exc, in_service}, {11'd0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/exception_controller.md
# exception_controller

Sequencing controller for the single-cycle MIPS core's three external exception sources (expsrc0..2). It latches requests, arbitrates by fixed priority, redirects the PC to a per-source handler vector, saves the return address, and redirects back on ERET. A service watchdog forces a return if a handler never issues ERET. It sits beside the PC-select logic of single_cycle_cpu and drives the next-PC override.

## Interface
- HANDLER_BASE, 32'h0000_0800, byte address of the source-0 handler vector
- VEC_SHIFT, 7, log2 of the byte stride between vectors (128 B)
- TIMEOUT, 1024, SERVICE cycles without ERET before the watchdog forces a return (>=2)
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- expsrc0 / expsrc1 / expsrc2  in  1 each  exception request lines, rising-edge sensitive
- pc_next  in  32  PC the core would load at the next edge without a redirect
- eret  in  1  current instruction is ERET
- mask_we  in  1  write enable for mask register
- mask_wdata  in  3  new mask value; bit i = 1 blocks source i
- pc_redirect  out  1  core must load redirect_pc instead of pc_next at the next edge
- redirect_pc  out  32  override target
- epc  out  32  saved return address
- cause  out  2  index of the source being or last serviced (0..2)
- in_service  out  1  state is SERVICE
- pending  out  3  latched, not yet serviced requests
- mask  out  3  current mask
- cnt_exc  out  11  exceptions taken, wraps 2047->0
- spurious_eret  out  1  sticky: ERET seen outside SERVICE
- wdog_fire  out  1  sticky: watchdog forced a return

## Operation
- Edge detect: prev_i samples expsrc_i each cycle. A cycle with expsrc_i=1 and prev_i=0 sets pending[i]. Masked requests still latch.
- Eligible = pending & ~mask. Priority is 0 > 1 > 2.
- States: RUN, SERVICE.
- RUN with eligible != 0:
  - pc_redirect=1; redirect_pc = HANDLER_BASE + (winner << VEC_SHIFT).
  - At the edge: epc<=pc_next, cause<=winner, pending[winner] cleared, cnt_exc+1, wdog counter<=0, state<=SERVICE.
- RUN with eret=1: no redirect; spurious_eret<=1.
- SERVICE:
  - New requests latch but are not taken. No nesting.
  - The wdog counter increments every cycle.
  - If eret=1, or the counter reaches TIMEOUT-1: pc_redirect=1, redirect_pc=epc, state<=RUN at the edge.
  - If the return is due to timeout without eret, wdog_fire<=1.
- Mask write (mask_we) takes effect at the edge. Eligibility in that cycle uses the old mask.
- Simultaneous events:
  - An edge on source i in the same cycle pending[i] is cleared by a take leaves pending[i]=1 (set wins).
  - eret and timeout in the same cycle count as an eret return; wdog_fire is unchanged.
  - A mask write during SERVICE is allowed.
- Return to RUN with eligible != 0: the next exception is taken in the first RUN cycle (back-to-back). epc then captures the return-target pc_next.

## Timing
- Reset values:
  - state RUN, prev=0, pending=0, mask=0, epc=0, cause=0, cnt_exc=0, wdog counter=0.
  - Both sticky flags 0, pc_redirect=0, redirect_pc=HANDLER_BASE, in_service=0.
- Reset mid-SERVICE aborts the handler; the state returns to RUN. A source held high across reset release registers one edge on the first clock.
- Request to redirect latency:
  - The edge on expsrc_i is sampled at edge N, so pending is visible after N.
  - pc_redirect is high in cycle N..N+1 (if eligible and RUN).
  - The handler's first instruction executes after edge N+1.
- pc_redirect and redirect_pc are combinational from registered state, pending, mask, epc, counter and eret only. They never depend on pc_next (no loop through PC mux).
- pc_redirect is high for exactly one cycle per take and one cycle per return.
- The watchdog return occurs in the TIMEOUT-th SERVICE cycle.

## Test plan
- Reset then pulse expsrc1 for 1 cycle with pc_next=0x40 -> pc_redirect high one cycle, redirect_pc=0x880, then epc=0x40, cause=1, cnt_exc=1, in_service=1. ERET 5 cycles later -> redirect_pc=0x40, state RUN.
- Edges on expsrc2 and expsrc0 in the same cycle -> source 0 taken first (redirect 0x800). After ERET, source 2 is taken on the first RUN cycle (redirect 0x900), cnt_exc=2.
- mask=3'b001, pulse expsrc0 -> no redirect, pending=3'b001. Write mask=0 -> take occurs in the cycle after the write edge.
- Enter SERVICE and never ERET (TIMEOUT=1024) -> redirect to epc in the 1024th SERVICE cycle, wdog_fire=1. A second case with eret in that same cycle -> wdog_fire stays 0.
- ERET in RUN -> no redirect, spurious_eret=1. Then assert reset during SERVICE -> all outputs return to reset values immediately, without waiting for clk.
- 2048 take/ERET pairs -> cnt_exc wraps to 0.
